// File: rtl/present_decrypt.sv
// present_decrypt: iterative PRESENT-80 decryption core, one round per cycle.
//
// A request is taken from IDLE. The core first rolls the user key forward to
// the last round key (31 cycles), whitens the ciphertext with it (1 cycle),
// then runs the 31 inverse rounds while rolling the key back (31 cycles).
// When the last inverse round finishes, the key register holds the user key
// again and the plaintext is presented.
//
// Ports:
//   clk_i    in   1   clock, rising edge
//   rst_ni   in   1   asynchronous active-low reset
//   start_i  in   1   decrypt request, sampled only in IDLE
//   key_i    in  80   user key (same key the encryptor uses), sampled with start_i
//   data_i   in  64   ciphertext, sampled with start_i
//   data_o   out 64   plaintext, registered, held until the next completion
//   busy_o   out  1   high while an operation is in progress
//   done_o   out  1   one-cycle completion pulse, data_o valid while high
module present_decrypt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [79:0] key_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    WHITEN = 2'd2,
    ROUND  = 2'd3
  } fsm_t;

  // Forward PRESENT S-box.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // Inverse PRESENT S-box.
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // One step of the encryptor's key schedule using round counter rc.
  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ rc;
    return t;
  endfunction

  // Exact inverse of key_fwd for the same rc: undo the xor, the S-box,
  // then rotate right by 61 (written as a left rotate by 19).
  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t        = k;
    t[19:15] = t[19:15] ^ rc;
    t[79:76] = sbox_inv(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  // Inverse bit permutation: output bit i is taken from where the forward
  // layer would have sent it, 16*i mod 63 (bit 63 stays put).
  function automatic logic [63:0] inv_p(input logic [63:0] d);
    logic [63:0] o;
    logic [5:0]  src;
    o   = 64'd0;
    src = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        src = 6'd63;
      end else begin
        src = 6'((i * 16) % 63);
      end
      o[6'(i)] = d[src];
    end
    return o;
  endfunction

  // Inverse S-box applied to all sixteen nibbles.
  function automatic logic [63:0] inv_s(input logic [63:0] d);
    logic [63:0] o;
    logic [5:0]  base;
    o    = 64'd0;
    base = 6'd0;
    for (int j = 0; j < 16; j++) begin
      base = 6'(j * 4);
      o[base +: 4] = sbox_inv(d[base +: 4]);
    end
    return o;
  endfunction

  fsm_t        fsm, fsm_nxt;
  logic [4:0]  rc, rc_nxt;
  logic [79:0] k, k_nxt;
  logic [63:0] blk, blk_nxt;
  logic [63:0] data_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic [79:0] kn;
  logic [63:0] round_out;

  // Next-state and datapath selection for every register in the core.
  always_comb begin
    fsm_nxt   = fsm;
    rc_nxt    = rc;
    k_nxt     = k;
    blk_nxt   = blk;
    data_nxt  = data_o;
    busy_nxt  = busy_o;
    done_nxt  = 1'b0;
    kn        = key_inv(k, rc);
    round_out = inv_s(inv_p(blk)) ^ kn[79:16];

    case (fsm)
      IDLE: begin
        if (start_i) begin
          fsm_nxt  = EXPAND;
          k_nxt    = key_i;
          blk_nxt  = data_i;
          rc_nxt   = 5'd1;
          busy_nxt = 1'b1;
        end else begin
          fsm_nxt  = IDLE;
          rc_nxt   = 5'd0;
          busy_nxt = 1'b0;
        end
      end

      EXPAND: begin
        k_nxt = key_fwd(k, rc);
        // rc is left at 31: the first inverse round uses the same counter.
        if (rc == 5'd31) begin
          fsm_nxt = WHITEN;
          rc_nxt  = rc;
        end else begin
          fsm_nxt = EXPAND;
          rc_nxt  = rc + 5'd1;
        end
      end

      WHITEN: begin
        blk_nxt = blk ^ k[79:16];
        fsm_nxt = ROUND;
        rc_nxt  = 5'd31;
      end

      ROUND: begin
        k_nxt   = kn;
        blk_nxt = round_out;
        if (rc == 5'd1) begin
          fsm_nxt  = IDLE;
          rc_nxt   = 5'd0;
          data_nxt = round_out;
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end else begin
          fsm_nxt  = ROUND;
          rc_nxt   = rc - 5'd1;
        end
      end

      default: begin
        fsm_nxt  = IDLE;
        rc_nxt   = 5'd0;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm    <= IDLE;
      rc     <= 5'd0;
      k      <= 80'd0;
      blk    <= 64'd0;
      data_o <= 64'd0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      fsm    <= fsm_nxt;
      rc     <= rc_nxt;
      k      <= k_nxt;
      blk    <= blk_nxt;
      data_o <= data_nxt;
      busy_o <= busy_nxt;
      done_o <= done_nxt;
    end
  end

endmodule
